// File: rtl/dac_serie_tx.sv
// Serializer feeding an SPI-style audio DAC: one-entry holding buffer with valid/ready,
// one FRAME-bit frame shifted out MSB first on every sample tick.
module dac_serie_tx #(
    parameter int         WIDTH      = 4,
    parameter logic [3:0] CTRL       = 4'h0,
    parameter int         FRAME      = 16,
    parameter int         SCLK_DIV   = 4,
    parameter int         SAMPLE_DIV = 2268
) (
    input  logic             clk100MHz,
    input  logic             reset,
    input  logic [WIDTH-1:0] dato_paralelo,
    input  logic             dato_valido,
    output logic             listo,
    output logic             sclk_DAC,
    output logic             sync_DAC,
    output logic             dato_SerieDAC,
    output logic             muestra_tick,
    output logic             trama_lista,
    output logic             subflujo
);
    localparam int CTRL_W = 4;
    localparam int TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int DIV_W  = $clog2(SCLK_DIV + 1);
    localparam int EDGE_W = $clog2(FRAME + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(FRAME);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t             state_q, state_d;
    logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [EDGE_W-1:0]  edge_q, edge_d;
    logic [FRAME-1:0]   shift_q, shift_d;
    logic [WIDTH-1:0]   hold_q, hold_d;
    logic [WIDTH-1:0]   last_q, last_d;
    logic               full_q, full_d;
    logic               sclk_q, sclk_d;
    logic               sync_q, sync_d;
    logic               dout_q, dout_d;
    logic               trama_q, trama_d;

    logic               tick;
    logic               load;
    logic [WIDTH-1:0]   sample_sel;
    logic [FRAME-1:0]   frame_word;

    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        load       = tick && (state_q == IDLE);
        sample_sel = full_q ? hold_q : last_q;

        frame_word = '0;
        frame_word[FRAME-1 -: CTRL_W]        = CTRL;
        frame_word[FRAME-CTRL_W-1 -: WIDTH]  = sample_sel;

        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

        // Holding buffer: a load empties it; a capture only happens while it was empty.
        hold_d = hold_q;
        full_d = full_q;
        last_d = last_q;
        if (load && full_q) begin
            full_d = 1'b0;
            last_d = hold_q;
        end
        if (dato_valido && !full_q) begin
            full_d = 1'b1;
            hold_d = dato_paralelo;
        end

        state_d = state_q;
        div_d   = div_q;
        edge_d  = edge_q;
        shift_d = shift_q;
        sclk_d  = sclk_q;
        sync_d  = sync_q;
        dout_d  = dout_q;
        trama_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = SHIFT;
                    shift_d = frame_word << 1;
                    dout_d  = frame_word[FRAME-1];
                    sync_d  = 1'b0;
                    sclk_d  = 1'b1;
                    div_d   = '0;
                    edge_d  = '0;
                end
            end
            SHIFT: begin
                div_d = div_q + 1'b1;
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        edge_d = edge_q + 1'b1;
                    end else if (edge_q == EDGE_LAST) begin
                        // Rising edge after the last DAC sample: close the frame.
                        sclk_d  = 1'b1;
                        sync_d  = 1'b1;
                        dout_d  = 1'b0;
                        state_d = GAP;
                    end else begin
                        sclk_d  = 1'b1;
                        dout_d  = shift_q[FRAME-1];
                        shift_d = shift_q << 1;
                    end
                end
            end
            GAP: begin
                div_d = div_q + 1'b1;
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = IDLE;
                    trama_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk100MHz or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            div_q      <= '0;
            edge_q     <= '0;
            shift_q    <= '0;
            hold_q     <= '0;
            last_q     <= '0;
            full_q     <= 1'b0;
            sclk_q     <= 1'b1;
            sync_q     <= 1'b1;
            dout_q     <= 1'b0;
            trama_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            div_q      <= div_d;
            edge_q     <= edge_d;
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            last_q     <= last_d;
            full_q     <= full_d;
            sclk_q     <= sclk_d;
            sync_q     <= sync_d;
            dout_q     <= dout_d;
            trama_q    <= trama_d;
        end
    end

    assign listo         = !full_q;
    assign sclk_DAC      = sclk_q;
    assign sync_DAC      = sync_q;
    assign dato_SerieDAC = dout_q;
    assign muestra_tick  = tick;
    assign trama_lista   = trama_q;
    assign subflujo      = load && !full_q;

endmodule

// File: tb/tb_dac_serie_tx.sv
// Bench for dac_serie_tx: directed scenarios plus random writes, checked against a
// sample-level model of the tick schedule, holding buffer and frame contents.
module tb_dac_serie_tx;
    localparam int WIDTH      = 4;
    localparam int FRAME      = 16;
    localparam int SCLK_DIV   = 2;
    localparam int SAMPLE_DIV = 200;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] dato_paralelo = '0;
    logic       dato_valido = 1'b0;
    logic       listo, sclk_DAC, sync_DAC, dato_SerieDAC;
    logic       muestra_tick, trama_lista, subflujo;

    int errors = 0;
    int checks = 0;

    dac_serie_tx #(
        .WIDTH(WIDTH), .CTRL(4'h0), .FRAME(FRAME),
        .SCLK_DIV(SCLK_DIV), .SAMPLE_DIV(SAMPLE_DIV)
    ) dut (
        .clk100MHz(clk), .reset(reset),
        .dato_paralelo(dato_paralelo), .dato_valido(dato_valido),
        .listo(listo), .sclk_DAC(sclk_DAC), .sync_DAC(sync_DAC),
        .dato_SerieDAC(dato_SerieDAC), .muestra_tick(muestra_tick),
        .trama_lista(trama_lista), .subflujo(subflujo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model state (what the DUT should hold, seen between clock edges)
    int         m_cnt = 0;
    bit         m_full = 0;
    logic [3:0] m_val = '0;
    logic [3:0] m_last = '0;
    logic [3:0] exp_q[$];
    // Frame observer state
    int          gap = -1;
    int          bits = 0;
    int          low = 0;
    bit          in_frame = 0;
    logic [15:0] acc = '0;
    logic [15:0] last_frame = '0;
    int          frames_done = 0;
    logic        prev_tick = 0, prev_sync = 1, prev_sclk = 1, prev_dout = 0;

    always @(negedge clk) begin
        logic exp_tick;
        bit   was_full;
        logic [3:0] e;
        if (reset) begin
            chk("rst_sync", sync_DAC, 1);
            chk("rst_sclk", sclk_DAC, 1);
            chk("rst_dout", dato_SerieDAC, 0);
            chk("rst_listo", listo, 1);
            chk("rst_pulses", {muestra_tick, trama_lista, subflujo}, 0);
            m_cnt = 0; m_full = 0; m_val = '0; m_last = '0;
            exp_q.delete();
            gap = -1; bits = 0; low = 0; in_frame = 0; acc = '0;
            prev_tick = 0; prev_sync = 1; prev_sclk = 1; prev_dout = 0;
        end else begin
            exp_tick = (m_cnt == SAMPLE_DIV - 1);
            was_full = m_full;
            chk("tick", muestra_tick, exp_tick);
            chk("listo", listo, !was_full);
            chk("subflujo", subflujo, exp_tick && !was_full);
            if (exp_tick) begin
                if (was_full) begin
                    exp_q.push_back(m_val);
                    m_last = m_val;
                    m_full = 0;
                end else begin
                    exp_q.push_back(m_last);
                end
            end
            if (dato_valido && !was_full) begin
                m_full = 1;
                m_val  = dato_paralelo;
            end
            m_cnt = (m_cnt + 1) % SAMPLE_DIV;

            if (gap >= 0) gap++;
            chk("trama", trama_lista, gap == SCLK_DIV);
            if (gap > SCLK_DIV) gap = -1;

            if (dato_SerieDAC !== prev_dout) chk("dout_while_sclk_high", sclk_DAC, 1);
            if (sync_DAC) chk("idle_lines", {sclk_DAC, dato_SerieDAC}, 2'b10);

            if (prev_sync && !sync_DAC) begin
                chk("load_after_tick", prev_tick, 1);
                in_frame = 1; bits = 0; low = 0; acc = '0;
            end
            if (!sync_DAC) low++;
            if (in_frame && prev_sclk && !sclk_DAC) begin
                acc = {acc[14:0], dato_SerieDAC};
                bits++;
            end
            if (in_frame && !prev_sync && sync_DAC) begin
                chk("falling_edges", bits, FRAME);
                chk("sync_low_cycles", low, 2 * SCLK_DIV * FRAME);
                chk("frame_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("frame_bits", acc, {4'h0, e, 8'h00});
                end
                last_frame = acc;
                frames_done++;
                in_frame = 0;
                gap = 0;
            end
            prev_tick = exp_tick; prev_sync = sync_DAC;
            prev_sclk = sclk_DAC; prev_dout = dato_SerieDAC;
        end
    end

    // Called at posedge+1; holds dato_valido until the DUT takes the sample.
    task automatic write_sample(input logic [3:0] v);
        int   n;
        logic was_ready;
        dato_paralelo = v;
        dato_valido   = 1'b1;
        for (n = 0; n < 600; n++) begin
            was_ready = listo;
            @(posedge clk); #1;
            if (was_ready) break;
        end
        chk("write_accepted", n < 600, 1);
        dato_valido = 1'b0;
    endtask

    task automatic wait_frame();
        int n;
        int n0;
        n0 = frames_done;
        for (n = 0; n < 700; n++) begin
            @(posedge clk); #1;
            if (frames_done != n0) break;
        end
        chk("frame_arrived", n < 700, 1);
    endtask

    task automatic wait_tick();
        int n;
        for (n = 0; n < 400; n++) begin
            @(posedge clk); #1;
            if (muestra_tick) break;
        end
        chk("tick_arrived", n < 400, 1);
    endtask

    initial begin
        int n;
        logic [3:0] v;
        int pause;

        repeat (3) @(posedge clk);
        #1;
        chk("t0_sync", sync_DAC, 1);
        chk("t0_listo", listo, 1);
        reset = 1'b0;

        // 1: reset mid-run takes effect immediately
        repeat (57) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("t1_sync", sync_DAC, 1);
        chk("t1_sclk", sclk_DAC, 1);
        chk("t1_dout", dato_SerieDAC, 0);
        chk("t1_listo", listo, 1);
        @(posedge clk); #1;
        reset = 1'b0;

        // 2: single sample A
        write_sample(4'hA);
        chk("t2_listo_low", listo, 0);
        wait_frame();
        chk("t2_frame", last_frame, 16'h0A00);

        // 3: A then 5 held with valid until accepted
        write_sample(4'hA);
        dato_paralelo = 4'h5;
        dato_valido   = 1'b1;
        chk("t3_listo_blocked", listo, 0);
        write_sample(4'h5);
        wait_frame();
        chk("t3_frame_a", last_frame, 16'h0A00);
        wait_frame();
        chk("t3_frame_5", last_frame, 16'h0500);

        // 4: no writes -> last sample re-sent
        wait_frame();
        chk("t4_resend", last_frame, 16'h0500);

        // 5: reset at bit 7 of a frame
        for (n = 0; n < 500; n++) begin
            @(posedge clk); #1;
            if (in_frame && bits == 7) break;
        end
        chk("t5_reach_bit7", n < 500, 1);
        #2 reset = 1'b1;
        #1;
        chk("t5_sync", sync_DAC, 1);
        chk("t5_sclk", sclk_DAC, 1);
        chk("t5_dout", dato_SerieDAC, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (n = 1; n <= 300; n++) begin
            @(posedge clk); #1;
            if (!sync_DAC) break;
        end
        chk("t5_restart_cycles", n, SAMPLE_DIV);

        // 6: sample offered in the tick cycle with empty buffer
        wait_tick();
        dato_paralelo = 4'h3;
        dato_valido   = 1'b1;
        chk("t6_subflujo", subflujo, 1);
        @(posedge clk); #1;
        dato_valido = 1'b0;
        wait_frame();
        chk("t6_frame_last", last_frame, 16'h0000);
        wait_frame();
        chk("t6_frame_3", last_frame, 16'h0300);

        // Random writes at random spacing
        for (int i = 0; i < 8; i++) begin
            v     = 4'($urandom_range(0, 15));
            pause = $urandom_range(0, 350);
            repeat (pause) @(posedge clk);
            #1;
            write_sample(v);
        end
        repeat (450) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
